act_mem_arbiter: RTL and testbench
==================================

// Module: act_mem_arbiter
// PURPOSE
//  Shares the single-write / single-read activation buffer between NUM_REQ requesters
//  (input loader, PE write-back, MAC fetch units).
//  Grants at most one write and one read per cycle, each with its own round-robin
//  pointer. Returns read data with a 1-cycle response tagged by requester id.
//  Sits between the layer datapath and the Activation memory.
// PARAMETERS
//  NUM_REQ  4   number of requesters (>=2)
//  DW       16  data width
//  AW       16  address width (full address; memory decodes {addr[15],addr[10:3]})
// PORTS
//  clk        in   1            clock, all logic on posedge
//  rst_n      in   1            synchronous reset, active low
//  req_valid  in   NUM_REQ      per-requester request valid
//  req_we     in   NUM_REQ      1=write, 0=read
//  req_addr   in   NUM_REQ*AW   request address, requester i at [i*AW +: AW]
//  req_wdata  in   NUM_REQ*DW   write data, requester i at [i*DW +: DW]
//  req_ready  out  NUM_REQ      one-hot-or-zero grant; transfer = valid&ready
//  rsp_valid  out  1            read data valid (no backpressure)
//  rsp_id     out  $clog2(NUM_REQ)  requester that issued the read
//  rsp_data   out  DW           read data
//  mem_we     out  1            to memory we
//  mem_waddr  out  AW           to memory waddr
//  mem_wdata  out  DW           to memory wdata
//  mem_addr   out  AW           to memory read addr
//  mem_rdata  in   DW           from memory rdata (registered in memory, 1 cycle)
// BEHAVIOUR
//  - Write port: candidates = req_valid & req_we. Grant the first candidate at or after
//    wr_ptr (wrapping). On grant g: wr_ptr <= (g+1) mod NUM_REQ. No grant: wr_ptr holds.
//  - Read port: same rule, candidates = req_valid & ~req_we, pointer rd_ptr.
//  - req_ready is combinational from req_valid/req_we/pointers; at most one write grant
//    and one read grant per cycle; a requester never holds ready without valid.
//  - mem_we = write granted; mem_waddr/mem_wdata = grantee's addr/data, else 0.
//  - mem_addr = read grantee's addr, else 0.
//  - Read granted in cycle N -> rsp_valid=1 in cycle N+1 with rsp_data=mem_rdata,
//    rsp_id=grantee. Registered. Throughput 1 read + 1 write per cycle.
//  - Read and write in same cycle to the same basic address {addr[15],addr[10:3]}
//    (aliased full addresses included): memory returns pre-write data (see CONFIG).
//  - Reset (rst_n=0 at a posedge): wr_ptr=0, rd_ptr=0, rsp_valid=0, rsp_id=0,
//    rsp_data=0. While rst_n=0: req_ready=0, mem_we=0. An in-flight read granted the cycle
//    before reset is dropped (no rsp_valid).
//  - Requesters keep valid/addr/data stable until ready; arbiter does not check this.
// CONFIGURATION
//  ACT_ARB_BYPASS_EN defined: same-cycle read/write hazard on equal basic address ->
//    rsp_data next cycle = granted write data (registered hit flag + data), not mem_rdata.
//  Not defined: no compare logic; rsp_data always mem_rdata (old value on hazard).
// STRUCTURE
//  act_mem_pkg: ACT_DW, ACT_AW, ACT_BASIC_AW=9, function act_basic_addr(addr)
//    returning {addr[15],addr[10:3]}.
//  Sub-module rr_arbiter (NUM_REQ, req vector, grant one-hot, registered pointer,
//    synchronous rst_n), instantiated twice: write port and read port.
// TESTING
//  1 rst_n=0 3 cycles, all req_valid=1 -> req_ready=0, mem_we=0, rsp_valid=0;
//    after release first grants go to req 0.
//  2 req0 write 0x0008<=0x1234; next cycle req1 read 0x0008 -> following cycle
//    rsp_valid=1, rsp_id=1, rsp_data=0x1234.
//  3 All 4 requesters writing continuously -> write grants 0,1,2,3,0,1.
//    Mixed: req0,2 write and req1,3 read together -> write 0,2,0; read 1,3,1.
//  4 Hazard: mem[0x8010]=0x0001; same cycle req0 write 0x8810<=0xBEEF (alias) and req1 read
//    0x8010 -> rsp_data=0x0001 without ACT_ARB_BYPASS_EN, 0xBEEF with it;
//    re-read returns 0xBEEF either way.
//  5 Read granted cycle N, rst_n=0 in cycle N+1 -> rsp_valid stays 0; pointers return to 0.
//  6 Only req3 valid (read) for 4 cycles -> granted every cycle, 4 responses with rsp_id=3.

Source files
------------

// File: rtl/act_mem_pkg.sv
// Shared definitions for the activation-memory arbiter slice.
//   ACT_DW         default data width
//   ACT_AW         full request address width
//   ACT_BASIC_AW   width of the address the memory actually decodes
//   act_basic_addr maps a full address onto the decoded basic address
//                  {addr[15], addr[10:3]}; addresses differing only in the
//                  other bits alias onto the same memory word.
package act_mem_pkg;

  localparam int unsigned ACT_DW       = 16;
  localparam int unsigned ACT_AW       = 16;
  localparam int unsigned ACT_BASIC_AW = 9;

  function automatic logic [ACT_BASIC_AW-1:0] act_basic_addr(input logic [ACT_AW-1:0] addr);
    return {addr[15], addr[10:3]};
  endfunction

endpackage

// File: rtl/act_mem_arbiter_rr.sv
// rr_arbiter: single-grant round-robin arbiter with a registered pointer.
// The search starts at ptr and wraps; on a grant to index g the pointer moves
// to (g+1) mod NUM_REQ, otherwise it holds. While rst_n is low no grant is
// issued and the pointer is cleared at the clock edge.
// Ports:
//   clk          clock, posedge
//   rst_n        synchronous reset, active low
//   req          request vector
//   grant        one-hot-or-zero grant (combinational)
//   grant_valid  some request was granted this cycle
//   grant_id     index of the granted request
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IW     = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [IW-1:0]      grant_id
);

  logic [IW-1:0] ptr;
  int unsigned   idx;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    grant_id    = '0;
    idx         = 0;
    if (rst_n) begin
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
        idx = (32'(ptr) + off) % NUM_REQ;
        if (!grant_valid && req[idx]) begin
          grant_valid = 1'b1;
          grant_id    = idx[IW-1:0];
        end
      end
      if (grant_valid) begin
        grant[grant_id] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/act_mem_arbiter.sv
// act_mem_arbiter: shares the single-write / single-read activation buffer
// between NUM_REQ requesters. Each cycle at most one write and one read are
// granted, each port with its own round-robin pointer. Read data returns one
// cycle after the grant, tagged with the requester id.
// Optional feature macro: ACT_ARB_BYPASS_EN -- when defined, a read and a
// write granted in the same cycle to the same basic address return the
// written data instead of the memory's pre-write data.
// Ports:
//   clk, rst_n              clock (posedge) and synchronous active-low reset
//   req_valid/req_we        per-requester valid and direction (1 = write)
//   req_addr/req_wdata      packed per-requester address / write data
//   req_ready               one-hot-or-zero grant, transfer = valid & ready
//   rsp_valid/rsp_id        read response valid and originating requester
//   rsp_data                read response data (0 when rsp_valid is low)
//   mem_we/mem_waddr/mem_wdata  memory write port
//   mem_addr/mem_rdata      memory read port (rdata registered in memory)
module act_mem_arbiter
  import act_mem_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DW      = ACT_DW,
  parameter int unsigned AW      = ACT_AW,
  localparam int unsigned IW     = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  rsp_valid,
  output logic [IW-1:0]         rsp_id,
  output logic [DW-1:0]         rsp_data,
  output logic                  mem_we,
  output logic [AW-1:0]         mem_waddr,
  output logic [DW-1:0]         mem_wdata,
  output logic [AW-1:0]         mem_addr,
  input  logic [DW-1:0]         mem_rdata
);

  logic [NUM_REQ-1:0] wr_grant;
  logic [NUM_REQ-1:0] rd_grant;
  logic               wr_valid;
  logic               rd_valid;
  logic [IW-1:0]      wr_id;
  logic [IW-1:0]      rd_id;
  logic               rsp_valid_q;
  logic [IW-1:0]      rsp_id_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req_valid & req_we),
    .grant       (wr_grant),
    .grant_valid (wr_valid),
    .grant_id    (wr_id)
  );

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req_valid & ~req_we),
    .grant       (rd_grant),
    .grant_valid (rd_valid),
    .grant_id    (rd_id)
  );

  // Write and read candidate sets are disjoint, so the OR stays one-hot per port.
  assign req_ready = wr_grant | rd_grant;

  always_comb begin
    mem_we    = wr_valid;
    mem_waddr = '0;
    mem_wdata = '0;
    mem_addr  = '0;
    if (wr_valid) begin
      mem_waddr = req_addr[wr_id*AW +: AW];
      mem_wdata = req_wdata[wr_id*DW +: DW];
    end
    if (rd_valid) begin
      mem_addr = req_addr[rd_id*AW +: AW];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      rsp_valid_q <= rd_valid;
      if (rd_valid) begin
        rsp_id_q <= rd_id;
      end
    end
  end

  // A response still registered when reset asserts is suppressed immediately,
  // so a read granted just before reset never shows rsp_valid.
  assign rsp_valid = rsp_valid_q & rst_n;
  assign rsp_id    = rsp_id_q;

`ifdef ACT_ARB_BYPASS_EN
  logic          hit_q;
  logic [DW-1:0] byp_data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      hit_q <= rd_valid && wr_valid &&
               (act_basic_addr(mem_addr) == act_basic_addr(mem_waddr));
      if (rd_valid && wr_valid) begin
        byp_data_q <= mem_wdata;
      end
    end
  end

  assign rsp_data = !rsp_valid ? '0 : (hit_q ? byp_data_q : mem_rdata);
`else
  assign rsp_data = rsp_valid ? mem_rdata : '0;
`endif

endmodule

// File: tb/tb_act_mem_arbiter.sv
module tb_act_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;
  logic        mem_we;
  logic [15:0] mem_waddr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;

  int tests;
  int fails;

  logic [15:0] mem [0:511];

  act_mem_arbiter #(.NUM_REQ(4), .DW(16), .AW(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] basic(input logic [15:0] a);
    return {a[15], a[10:3]};
  endfunction

  // Activation memory: registered read, returns pre-write data on collision.
  always @(posedge clk) begin
    if (mem_we) mem[basic(mem_waddr)] <= mem_wdata;
    mem_rdata <= mem[basic(mem_addr)];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic we,
                       input logic [15:0] a, input logic [15:0] d);
    req_valid[i]         = v;
    req_we[i]            = we;
    req_addr[i*16 +: 16]  = a;
    req_wdata[i*16 +: 16] = d;
  endtask

  task automatic do_reset;
    req_valid = '0;
    rst_n     = 1'b0;
    tick();
    rst_n     = 1'b1;
  endtask

  initial begin
    int          exp_w3 [6];
    int          exp_mw [3];
    int          exp_mr [3];
    logic [15:0] exp_hz;

    exp_w3 = '{0, 1, 2, 3, 0, 1};
    exp_mw = '{0, 2, 0};
    exp_mr = '{1, 3, 1};
`ifdef ACT_ARB_BYPASS_EN
    exp_hz = 16'hBEEF;
`else
    exp_hz = 16'h0001;
`endif
    tests = 0;
    fails = 0;
    for (int i = 0; i < 512; i++) mem[i] = '0;

    // 1: reset with every requester asking
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_we    = 4'hF;
    req_addr  = '0;
    req_wdata = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_mem_we", 32'(mem_we), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    end
    rst_n = 1'b1;
    #1;
    chk("post_rst_first_grant", 32'(req_ready), 32'h1);
    chk("post_rst_mem_we", 32'(mem_we), 32'h1);
    req_valid = '0;

    // 2: write then read back through another requester
    tick();
    drive(0, 1'b1, 1'b1, 16'h0008, 16'h1234);
    #1;
    chk("wr_ready", 32'(req_ready), 32'h1);
    chk("wr_waddr", 32'(mem_waddr), 32'h0008);
    chk("wr_wdata", 32'(mem_wdata), 32'h1234);
    tick();
    req_valid = '0;
    drive(1, 1'b1, 1'b0, 16'h0008, 16'h0000);
    #1;
    chk("rd_ready", 32'(req_ready), 32'h2);
    chk("rd_addr", 32'(mem_addr), 32'h0008);
    tick();
    req_valid = '0;
    chk("rd_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("rd_rsp_id", 32'(rsp_id), 32'h1);
    chk("rd_rsp_data", 32'(rsp_data), 32'h1234);
    tick();
    chk("rd_rsp_done", 32'(rsp_valid), 32'h0);

    // 3a: all four writing continuously
    do_reset();
    for (int i = 0; i < 4; i++) drive(i, 1'b1, 1'b1, 16'(16'h0100 + i*8), 16'(16'hA000 + i));
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_wr_ready", 32'(req_ready), 32'(1 << exp_w3[k]));
      chk("rr_wr_waddr", 32'(mem_waddr), 32'(16'h0100 + exp_w3[k]*8));
      tick();
    end
    req_valid = '0;

    // 3b: mixed reads and writes
    do_reset();
    drive(0, 1'b1, 1'b1, 16'h0100, 16'hB000);
    drive(1, 1'b1, 1'b0, 16'h0200, 16'h0000);
    drive(2, 1'b1, 1'b1, 16'h0110, 16'hB002);
    drive(3, 1'b1, 1'b0, 16'h0210, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("mix_ready", 32'(req_ready), 32'((1 << exp_mw[k]) | (1 << exp_mr[k])));
      if (k > 0) begin
        chk("mix_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("mix_rsp_id", 32'(rsp_id), 32'(exp_mr[k-1]));
      end
      tick();
    end
    req_valid = '0;
    chk("mix_rsp_id_last", 32'(rsp_id), 32'(exp_mr[2]));

    // 4: same-cycle hazard on aliased basic address
    do_reset();
    drive(0, 1'b1, 1'b1, 16'h8010, 16'h0001);
    #1;
    chk("hz_seed_ready", 32'(req_ready), 32'h1);
    tick();
    drive(0, 1'b1, 1'b1, 16'h8810, 16'hBEEF);
    drive(1, 1'b1, 1'b0, 16'h8010, 16'h0000);
    #1;
    chk("hz_ready", 32'(req_ready), 32'h3);
    chk("hz_waddr", 32'(mem_waddr), 32'h8810);
    chk("hz_raddr", 32'(mem_addr), 32'h8010);
    tick();
    req_valid = '0;
    chk("hz_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("hz_rsp_data", 32'(rsp_data), 32'(exp_hz));
    drive(1, 1'b1, 1'b0, 16'h8010, 16'h0000);
    #1;
    chk("hz_reread_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    chk("hz_reread_data", 32'(rsp_data), 32'hBEEF);

    // 5: reset right after a read grant drops the response
    tick();
    drive(2, 1'b1, 1'b0, 16'h0008, 16'h0000);
    #1;
    chk("drop_rd_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    rst_n     = 1'b0;
    #1;
    chk("drop_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("drop_rsp_data", 32'(rsp_data), 32'h0);
    tick();
    chk("drop_rsp_valid2", 32'(rsp_valid), 32'h0);
    chk("drop_rsp_id", 32'(rsp_id), 32'h0);
    rst_n     = 1'b1;
    req_valid = 4'hF;
    req_we    = 4'hF;
    #1;
    chk("drop_wr_ptr0", 32'(req_ready), 32'h1);
    req_we = 4'h0;
    #1;
    chk("drop_rd_ptr0", 32'(req_ready), 32'h1);
    req_valid = '0;

    // 6: lone reader gets every cycle
    tick();
    drive(3, 1'b1, 1'b0, 16'h0008, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("solo_ready", 32'(req_ready), 32'h8);
      if (k > 0) begin
        chk("solo_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("solo_rsp_id", 32'(rsp_id), 32'h3);
        chk("solo_rsp_data", 32'(rsp_data), 32'h1234);
      end
      tick();
    end
    req_valid = '0;
    chk("solo_rsp_valid_last", 32'(rsp_valid), 32'h1);
    chk("solo_rsp_id_last", 32'(rsp_id), 32'h3);
    chk("solo_rsp_data_last", 32'(rsp_data), 32'h1234);
    tick();
    chk("solo_rsp_done", 32'(rsp_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
